// File: rtl/dmem_mmio_responder.sv
// Data-memory responder for the processor dmem port: word RAM plus an MMIO window
// with LEDs, sticky button-edge flags, a free-running cycle counter and a down-timer.
module dmem_mmio_responder #(
  parameter int ADDR_W    = 12,
  parameter int LED_W     = 8,
  parameter int BTN_W     = 4,
  parameter     INIT_FILE = ""
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       address_dmem,
  input  logic [31:0]       data,
  input  logic              wren,
  output logic [31:0]       q_dmem,
  input  logic [BTN_W-1:0]  btn_in,
  output logic [LED_W-1:0]  leds,
  output logic              timer_irq
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [2:0] {
    REG_LED    = 3'd0,
    REG_BTN    = 3'd1,
    REG_CYCLES = 3'd2,
    REG_TIMER  = 3'd3,
    REG_TSTAT  = 3'd4
  } mmio_reg_e;

  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] idx;
  logic [2:0]        reg_sel;
  logic              is_mmio;
  logic              ram_we;
  logic              mmio_we;

  logic [BTN_W-1:0]  btn_sync1;
  logic [BTN_W-1:0]  btn_sync2;
  logic [BTN_W-1:0]  btn_prev;
  logic [BTN_W-1:0]  btn_rise;
  logic [BTN_W-1:0]  btn_clr;
  logic [BTN_W-1:0]  btn_stat;
  logic [31:0]       cycles;
  logic [31:0]       timer_count;
  logic              expired;
  logic [31:0]       rd_data;

  // Bits outside the RAM index and the MMIO register field are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, address_dmem[30:ADDR_W+2], address_dmem[1:0]};

  assign is_mmio   = address_dmem[31];
  assign idx       = address_dmem[ADDR_W+1:2];
  assign reg_sel   = address_dmem[4:2];
  assign ram_we    = wren && !is_mmio;
  assign mmio_we   = wren && is_mmio;
  assign btn_rise  = btn_sync2 & ~btn_prev;
  assign timer_irq = expired;

  // NOTE: the RAM array has no reset so it maps onto block RAM; gating on reset
  // still drops a write whose edge lands while reset is held.
  always_ff @(posedge clock) begin
    if (ram_we && reset) begin
      mem[idx] <= data;
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves a latch.
  always_comb begin
    rd_data = '0;
    btn_clr = '0;
    if (mmio_we && reg_sel == REG_BTN) begin
      btn_clr = data[BTN_W-1:0];
    end
    if (!is_mmio) begin
      rd_data = mem[idx];
    end else begin
      case (reg_sel)
        REG_LED:    rd_data[LED_W-1:0] = leds;
        REG_BTN:    rd_data[BTN_W-1:0] = btn_stat;
        REG_CYCLES: rd_data            = cycles;
        REG_TIMER:  rd_data            = timer_count;
        REG_TSTAT:  rd_data[0]         = expired;
        default:    rd_data            = '0;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees
  // pre-edge values, which is what gives read-before-write on q_dmem.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q_dmem      <= '0;
      leds        <= '0;
      btn_sync1   <= '0;
      btn_sync2   <= '0;
      btn_prev    <= '0;
      btn_stat    <= '0;
      cycles      <= '0;
      timer_count <= '0;
      expired     <= 1'b0;
    end else begin
      q_dmem    <= rd_data;
      cycles    <= cycles + 32'd1;
      btn_sync1 <= btn_in;
      btn_sync2 <= btn_sync1;
      btn_prev  <= btn_sync2;
      // A new edge on the same bit as a W1C wins, so no press is lost.
      btn_stat  <= (btn_stat & ~btn_clr) | btn_rise;

      if (mmio_we && reg_sel == REG_LED) begin
        leds <= data[LED_W-1:0];
      end

      if (mmio_we && reg_sel == REG_TIMER) begin
        timer_count <= data;
        expired     <= (data == 32'd0);
      end else if (timer_count != 32'd0) begin
        timer_count <= timer_count - 32'd1;
        if (timer_count == 32'd1) begin
          expired <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Scoreboard bench for dmem_mmio_responder: a stimulus process pushes expected results
// from an abstract model; a monitor pops and compares after every rising edge.
module tb_dmem_mmio_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] address_dmem;
  logic [31:0] data;
  logic        wren;
  logic [31:0] q_dmem;
  logic [3:0]  btn_in;
  logic [7:0]  leds;
  logic        timer_irq;

  dmem_mmio_responder dut (
    .clock        (clock),
    .reset        (reset),
    .address_dmem (address_dmem),
    .data         (data),
    .wren         (wren),
    .q_dmem       (q_dmem),
    .btn_in       (btn_in),
    .leds         (leds),
    .timer_irq    (timer_irq)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          chk_q;
    logic [31:0] q;
    logic [7:0]  leds;
    logic        irq;
    string       name;
  } exp_t;

  exp_t sb[$];

  // Reference model: state is described by what has happened since reset,
  // not by the register pipeline inside the design.
  logic [31:0] ram_m [int];
  int unsigned e;          // completed edges since reset release
  logic [31:0] cyc_off;    // counter value = cyc_off + e
  logic [7:0]  m_leds;
  logic [3:0]  m_stat;
  bit          t_loaded;
  logic [31:0] t_v;
  int unsigned t_e;        // edge count right after the last TIMER write
  logic [3:0]  samp[$];    // samp[k] = buttons seen at edge k; samp[0] = before release
  logic [3:0]  btn_cur = 4'h0;

  function automatic logic [31:0] t_count(input int unsigned at);
    longint rem;
    if (!t_loaded) return 32'd0;
    rem = longint'(t_v) - longint'(at - t_e);
    if (rem < 0) return 32'd0;
    return rem[31:0];
  endfunction

  function automatic bit t_expired(input int unsigned at);
    return t_loaded && (t_count(at) == 32'd0);
  endfunction

  task automatic model_reset();
    e        = 0;
    cyc_off  = 32'd0;
    m_leds   = 8'h00;
    m_stat   = 4'h0;
    t_loaded = 1'b0;
    t_v      = 32'd0;
    t_e      = 0;
    samp.delete();
    samp.push_back(4'h0);
  endtask

  task automatic drive_now(input logic [31:0] a, input logic [31:0] d, input logic we,
                           input logic [3:0] btn, input string name);
    exp_t        x;
    logic [31:0] rd;
    logic [3:0]  rise;
    int          ri;
    int unsigned k;
    address_dmem = a;
    data         = d;
    wren         = we;
    btn_in       = btn;
    ri           = int'(a[13:2]);
    x.chk_q      = 1'b1;
    rd           = 32'd0;
    if (!a[31]) begin
      if (ram_m.exists(ri)) rd = ram_m[ri];
      else x.chk_q = 1'b0;
    end else begin
      case (a[4:2])
        3'd0:    rd = {24'd0, m_leds};
        3'd1:    rd = {28'd0, m_stat};
        3'd2:    rd = cyc_off + e;
        3'd3:    rd = t_count(e);
        3'd4:    rd = {31'd0, t_expired(e)};
        default: rd = 32'd0;
      endcase
    end
    x.q = rd;

    // A button edge becomes visible two edges after it is first sampled.
    k = e + 1;
    samp.push_back(btn);
    rise = 4'h0;
    if (k >= 2) rise = samp[k-2] & ~((k >= 3) ? samp[k-3] : 4'h0);
    if (we && !a[31]) ram_m[ri] = d;
    if (we && a[31]) begin
      case (a[4:2])
        3'd0: m_leds = d[7:0];
        3'd1: m_stat = m_stat & ~d[3:0];
        3'd3: begin
          t_loaded = 1'b1;
          t_v      = d;
          t_e      = k;
        end
        default: ;
      endcase
    end
    m_stat = m_stat | rise;
    e      = k;

    x.leds = m_leds;
    x.irq  = t_expired(e);
    x.name = name;
    sb.push_back(x);
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic we,
                       input logic [3:0] btn, input string name);
    @(negedge clock);
    drive_now(a, d, we, btn, name);
  endtask

  task automatic release_reset();
    @(negedge clock);
    reset = 1'b1;
    model_reset();
    drive_now(32'h8000_0014, 32'd0, 1'b0, btn_cur, "rel");
  endtask

  task automatic random_ops(input int n);
    logic [31:0] a;
    logic [31:0] d;
    logic        we;
    int          b;
    int          rs;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        b = $urandom_range(0, 3);
        btn_cur[b] = ~btn_cur[b];
      end
      if ($urandom_range(0, 1) == 1) begin
        a = {1'b0, 17'($urandom), 12'($urandom_range(0, 15)), 2'b00};
      end else begin
        rs = $urandom_range(0, 7);
        a = {1'b1, 26'($urandom), 3'(rs), 2'b00};
      end
      we = ($urandom_range(0, 2) == 0);
      d  = $urandom;
      if (a[31] && a[4:2] == 3'd3) d = $urandom_range(0, 8);
      drive(a, d, we, btn_cur, "rnd");
    end
  endtask

  // Monitor: q_dmem is valid after every edge, so one expectation is consumed per edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clock);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        if (x.chk_q) check({x.name, "_q"}, q_dmem, x.q);
        check({x.name, "_leds"}, {24'd0, leds}, {24'd0, x.leds});
        check({x.name, "_irq"}, {31'd0, timer_irq}, {31'd0, x.irq});
      end
    end
  end

  initial begin
    reset        = 1'b0;
    address_dmem = 32'd0;
    data         = 32'd0;
    wren         = 1'b0;
    btn_in       = 4'h0;
    model_reset();
    repeat (2) @(negedge clock);
    #1;
    check("por_q", q_dmem, 32'd0);
    check("por_leds", {24'd0, leds}, 32'd0);
    check("por_irq", {31'd0, timer_irq}, 32'd0);
    release_reset();

    // RAM write, read-back, read-before-write on the same edge
    drive(32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 4'h0, "ram_wr");
    drive(32'h0000_0010, 32'd0,         1'b0, 4'h0, "ram_rd");
    drive(32'h0000_0010, 32'h0000_0001, 1'b1, 4'h0, "ram_rbw");
    drive(32'h0000_0010, 32'd0,         1'b0, 4'h0, "ram_new");

    // LEDs
    drive(32'h8000_0000, 32'hFFFF_FFA5, 1'b1, 4'h0, "led_wr");
    drive(32'h8000_0000, 32'd0,         1'b0, 4'h0, "led_rd");

    // Button pulse, sticky flag, W1C, and edge coinciding with W1C
    repeat (5) drive(32'h8000_0004, 32'd0, 1'b0, 4'h4, "btn_hold");
    repeat (4) drive(32'h8000_0004, 32'd0, 1'b0, 4'h0, "btn_rel");
    drive(32'h8000_0004, 32'h4, 1'b1, 4'h0, "btn_w1c");
    drive(32'h8000_0004, 32'd0, 1'b0, 4'h0, "btn_clr");
    drive(32'h8000_0004, 32'd0, 1'b0, 4'h2, "btn_e0");
    drive(32'h8000_0004, 32'd0, 1'b0, 4'h2, "btn_e1");
    drive(32'h8000_0004, 32'h2, 1'b1, 4'h2, "btn_race");
    drive(32'h8000_0004, 32'd0, 1'b0, 4'h2, "btn_win");
    drive(32'h8000_0004, 32'h2, 1'b1, 4'h0, "btn_w1c2");

    // Timer countdown, reload, zero load
    drive(32'h8000_000C, 32'd3, 1'b1, 4'h0, "tmr_ld3");
    repeat (5) drive(32'h8000_000C, 32'd0, 1'b0, 4'h0, "tmr_cnt");
    drive(32'h8000_0010, 32'd0,  1'b0, 4'h0, "tstat_exp");
    drive(32'h8000_000C, 32'd10, 1'b1, 4'h0, "tmr_ld10");
    drive(32'h8000_0010, 32'd0,  1'b0, 4'h0, "tstat_run");
    drive(32'h8000_000C, 32'd0,  1'b1, 4'h0, "tmr_ld0");
    drive(32'h8000_0010, 32'd0,  1'b0, 4'h0, "tstat_z");

    // Cycle counter: spacing, ignored write, and wrap from near all-ones
    drive(32'h8000_0008, 32'd0, 1'b0, 4'h0, "cyc_a");
    drive(32'h8000_0008, 32'h1234_5678, 1'b1, 4'h0, "cyc_wr");
    repeat (5) drive(32'h8000_0014, 32'hFFFF_FFFF, 1'b1, 4'h0, "hole");
    drive(32'h8000_0008, 32'd0, 1'b0, 4'h0, "cyc_b");
    @(negedge clock);
    force dut.cycles = 32'hFFFF_FFFC;
    #1;
    release dut.cycles;
    cyc_off = 32'hFFFF_FFFC - e;
    drive_now(32'h8000_0008, 32'd0, 1'b0, 4'h0, "cyc_wrap");
    repeat (7) drive(32'h8000_0008, 32'd0, 1'b0, 4'h0, "cyc_wrap");

    random_ops(600);

    // Asynchronous reset mid-countdown; RAM survives, writes during reset are dropped
    btn_cur = 4'h0;
    drive(32'h0000_0190, 32'h1234_5678, 1'b1, 4'h0, "pre_ram");
    drive(32'h8000_0000, 32'h0000_00FF, 1'b1, 4'h0, "pre_led");
    drive(32'h8000_000C, 32'd50,        1'b1, 4'h0, "pre_tmr");
    repeat (3) drive(32'h8000_000C, 32'd0, 1'b0, 4'h0, "pre_cnt");
    @(negedge clock);
    btn_in = 4'h1;
    #2;
    reset = 1'b0;
    #1;
    check("rst_q", q_dmem, 32'd0);
    check("rst_leds", {24'd0, leds}, 32'd0);
    check("rst_irq", {31'd0, timer_irq}, 32'd0);
    repeat (3) begin
      @(negedge clock);
      address_dmem = 32'h0000_0190;
      data         = 32'h0000_0BAD;
      wren         = 1'b1;
    end
    btn_cur = 4'h1;
    release_reset();
    drive(32'h0000_0190, 32'd0, 1'b0, 4'h1, "post_ram");
    drive(32'h8000_000C, 32'd0, 1'b0, 4'h1, "post_tmr");
    repeat (4) drive(32'h8000_0004, 32'd0, 1'b0, 4'h1, "post_btn");
    drive(32'h8000_0008, 32'd0, 1'b0, 4'h1, "post_cyc");

    random_ops(150);

    repeat (4) @(posedge clock);
    #2;
    check("sb_drain", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
